// File: rtl/sigmoid_act_stage.sv
// rtl/sigmoid_act_stage.sv - PLAN sigmoid activation stage between two neuron layers
// Q8.16 pre-activation in, rounded Q4.8 sample out, with one-deep pending buffer and ack watchdog.
module sigmoid_act_stage #(
  parameter int ACK_TIMEOUT = 8,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [23:0]      in_data,
  output logic [11:0]      out_data,
  output logic             out_start,
  input  logic             out_ack,
  output logic             busy,
  output logic             overrun,
  output logic             ack_err,
  output logic [CNT_W-1:0] sample_cnt
);

  localparam int WD_W = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ABS,
    S_SEG,
    S_FIX,
    S_SEND,
    S_WAIT_ACK
  } state_t;

  state_t      state;
  logic [23:0] x_reg;
  logic [23:0] a_reg;
  logic        sign_reg;
  logic [16:0] yp_reg;
  logic        pend_full;
  logic [23:0] pend_data;
  logic [WD_W-1:0] wdog;

  logic [23:0] abs_val;
  logic [16:0] seg_yp;
  logic [23:0] y_val;
  logic [23:0] q_val;
  logic [11:0] fix_out;

  // 0x800000 negates to itself, which is the correct unsigned magnitude.
  assign abs_val = x_reg[23] ? (~x_reg + 24'd1) : x_reg;

  always_comb begin
    seg_yp = 17'd65536;
    if (a_reg >= 24'd327680)
      seg_yp = 17'd65536;
    else if (a_reg >= 24'd155648)
      seg_yp = 17'((a_reg >> 5) + 24'd55296);
    else if (a_reg >= 24'd65536)
      seg_yp = 17'((a_reg >> 3) + 24'd40960);
    else
      seg_yp = 17'((a_reg >> 2) + 24'd32768);
  end

  assign y_val   = sign_reg ? (24'd65536 - 24'(yp_reg)) : 24'(yp_reg);
  assign q_val   = (y_val + 24'd128) >> 8;
  assign fix_out = (q_val > 24'd256) ? 12'd256 : q_val[11:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      x_reg      <= '0;
      a_reg      <= '0;
      sign_reg   <= 1'b0;
      yp_reg     <= '0;
      pend_full  <= 1'b0;
      pend_data  <= '0;
      wdog       <= '0;
      out_data   <= '0;
      out_start  <= 1'b0;
      busy       <= 1'b0;
      overrun    <= 1'b0;
      ack_err    <= 1'b0;
      sample_cnt <= '0;
    end else begin
      out_start <= 1'b0;

      // Inputs arriving outside IDLE park in the pending slot or are dropped.
      if (state != S_IDLE && in_valid) begin
        if (!pend_full) begin
          pend_data <= in_data;
          pend_full <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end

      case (state)
        S_IDLE: begin
          if (pend_full) begin
            x_reg <= pend_data;
            state <= S_ABS;
            busy  <= 1'b1;
            if (in_valid)
              pend_data <= in_data;
            else
              pend_full <= 1'b0;
          end else if (in_valid) begin
            x_reg <= in_data;
            state <= S_ABS;
            busy  <= 1'b1;
          end
        end
        S_ABS: begin
          sign_reg <= x_reg[23];
          a_reg    <= abs_val;
          state    <= S_SEG;
        end
        S_SEG: begin
          yp_reg <= seg_yp;
          state  <= S_FIX;
        end
        S_FIX: begin
          out_data <= fix_out;
          state    <= S_SEND;
        end
        S_SEND: begin
          out_start  <= 1'b1;
          sample_cnt <= sample_cnt + CNT_W'(1);
          wdog       <= '0;
          state      <= S_WAIT_ACK;
        end
        S_WAIT_ACK: begin
          if (out_ack) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end else if (wdog == WD_W'(ACK_TIMEOUT - 1)) begin
            ack_err <= 1'b1;
            state   <= S_IDLE;
            busy    <= 1'b0;
          end else begin
            wdog <= wdog + WD_W'(1);
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sigmoid_act_stage.sv
// tb/tb_sigmoid_act_stage.sv - directed scoreboard bench for sigmoid_act_stage
module tb_sigmoid_act_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic [23:0] in_data = '0;
  logic [11:0] out_data;
  logic        out_start;
  logic        out_ack = 1'b0;
  logic        busy;
  logic        overrun;
  logic        ack_err;
  logic [15:0] sample_cnt;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int unsigned exp_q[$];
  bit ack_en = 1'b1;
  bit prev_start = 1'b0;

  sigmoid_act_stage #(.ACK_TIMEOUT(8), .CNT_W(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .out_data   (out_data),
    .out_start  (out_start),
    .out_ack    (out_ack),
    .busy       (busy),
    .overrun    (overrun),
    .ack_err    (ack_err),
    .sample_cnt (sample_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Scoreboard consumer plus a downstream model that acks one cycle after each start.
  always @(negedge clk) begin
    if (out_start === 1'b1) begin
      check("start_not_back_to_back", 32'(prev_start), 0);
      check("start_was_expected", 32'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0)
        check("out_data", 32'(out_data), exp_q.pop_front());
    end
    out_ack    = ack_en && prev_start;
    prev_start = (out_start === 1'b1);
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: observed cycle %0d expected completion", cyc);
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    in_valid = 1'b0;
    tick(2);
    reset = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int i;
    for (i = 0; i < budget; i++) begin
      if (busy === 1'b0 && exp_q.size() == 0) break;
      tick(1);
    end
    check({tag, "_idle_timeout"}, 32'(i < budget), 1);
  endtask

  task automatic send_one(input logic [23:0] d, input int unsigned exp);
    int t0;
    int i;
    in_valid = 1'b1;
    in_data  = d;
    exp_q.push_back(exp);
    t0 = cyc + 1;
    tick(1);
    in_valid = 1'b0;
    for (i = 0; i < 20 && out_start !== 1'b1; i++) tick(1);
    check("start_seen", 32'(out_start === 1'b1), 1);
    check("latency_edges", 32'(cyc - t0), 4);
    tick(1);
    wait_idle(20, "send");
  endtask

  logic [23:0] tv_d [10] = '{24'h000000, 24'h008000, 24'h010000, 24'h030000, 24'h050000,
                             24'hFF0000, 24'h7FFFFF, 24'h800000, 24'h000200, 24'hFFFE00};
  int unsigned tv_e [10] = '{128, 160, 192, 240, 256, 64, 256, 0, 129, 128};

  initial begin
    int i;
    tick(1);
    do_reset();
    tick(1);
    check("rst_out_data", 32'(out_data), 0);
    check("rst_out_start", 32'(out_start), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_overrun", 32'(overrun), 0);
    check("rst_ack_err", 32'(ack_err), 0);
    check("rst_sample_cnt", 32'(sample_cnt), 0);
    for (int k = 0; k < 10; k++) begin
      tick(1);
      check("idle_no_start", 32'(out_start), 0);
    end

    for (int k = 0; k < 10; k++) send_one(tv_d[k], tv_e[k]);
    check("table_sample_cnt", 32'(sample_cnt), 10);
    check("table_overrun", 32'(overrun), 0);

    // Three back-to-back inputs: third hits a full pending slot.
    do_reset();
    in_valid = 1'b1; in_data = 24'h010000; exp_q.push_back(192); tick(1);
    in_data = 24'h030000; exp_q.push_back(240); tick(1);
    in_data = 24'h050000; tick(1);
    in_valid = 1'b0;
    tick(1);
    wait_idle(60, "b2b");
    check("b2b_overrun", 32'(overrun), 1);
    check("b2b_sample_cnt", 32'(sample_cnt), 2);

    // Ack watchdog.
    ack_en = 1'b0;
    in_valid = 1'b1; in_data = 24'h008000; exp_q.push_back(160); tick(1);
    in_valid = 1'b0;
    for (i = 0; i < 20 && out_start !== 1'b1; i++) tick(1);
    check("wd_start_seen", 32'(out_start === 1'b1), 1);
    for (int k = 0; k < 7; k++) begin
      tick(1);
      check("wd_ack_err_early", 32'(ack_err), 0);
      check("wd_busy_waiting", 32'(busy), 1);
    end
    tick(1);
    check("wd_ack_err_set", 32'(ack_err), 1);
    check("wd_back_idle", 32'(busy), 0);
    ack_en = 1'b1;
    send_one(24'h010000, 192);
    check("wd_ack_err_sticky", 32'(ack_err), 1);
    check("wd_sample_cnt", 32'(sample_cnt), 4);

    // Reset while the sample sits in SEG.
    in_valid = 1'b1; in_data = 24'h030000; tick(1);
    in_valid = 1'b0; tick(1);
    do_reset();
    check("abort_sample_cnt", 32'(sample_cnt), 0);
    check("abort_busy", 32'(busy), 0);
    check("abort_ack_err", 32'(ack_err), 0);
    tick(8);
    send_one(24'h010000, 192);
    check("abort_next_sample_cnt", 32'(sample_cnt), 1);

    check("scoreboard_drained", 32'(exp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sigmoid_act_stage.md
Name: sigmoid_act_stage

Overview:
Downstream activation stage for the 36-input fixed-point neuron. It consumes the neuron's 24-bit Q8.16 pre-activation sum (f_out/ready) and applies a piecewise-linear (PLAN) sigmoid. It quantises the result to a 12-bit Q4.8 sample and drives it into the next layer's neuron sample port (x_in/start/ack). A one-deep pending buffer absorbs back-to-back results, and an ack watchdog flags a stalled consumer.

Parameters:
ACK_TIMEOUT, 8, max cycles spent in WAIT_ACK before giving up on out_ack (>=1)
CNT_W, 16, width of the emitted-sample counter

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
in_valid  input  1  one-cycle pulse, connect to neuron ready; in_data valid this cycle
in_data  input  24  pre-activation, signed two's complement Q8.16 (1.0 = 65536)
out_data  output  12  activation, unsigned Q4.8, range 0..256 (1.0 = 256); connect to next x_in
out_start  output  1  one-cycle sample strobe; connect to next neuron start
out_ack  input  1  sample-accepted acknowledge from next neuron (its ack)
busy  output  1  high in every state except IDLE
overrun  output  1  sticky: an input was dropped
ack_err  output  1  sticky: ACK_TIMEOUT expired without out_ack
sample_cnt  output  CNT_W  count of out_start pulses issued, wraps modulo 2^CNT_W

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high.
- Reset values: state=IDLE, out_data=0, out_start=0, busy=0, overrun=0, ack_err=0, sample_cnt=0, pending buffer empty, watchdog=0. Reset mid-operation aborts the sample in flight. No out_start is issued after reset until a new in_valid arrives.
- FSM states: IDLE -> ABS -> SEG -> FIX -> SEND -> WAIT_ACK -> IDLE.
  - IDLE: if the pending buffer is full, load it (pending buffer empties) and go to ABS. Otherwise, if in_valid, capture in_data and go to ABS. Pending has priority over a coincident in_valid; that in_valid goes into pending.
  - ABS: sign = x[23]; a = |x| as a 24-bit unsigned value. x = 0x800000 gives a = 0x800000, with no overflow.
  - SEG: compute yp (Q16, 17 bits) from a. Breakpoints use a >= 1.0 / 2.375 / 5.0, i.e. 65536 / 155648 / 327680.
    - a >= 327680: yp = 65536.
    - a >= 155648: yp = (a>>5) + 55296.
    - a >= 65536: yp = (a>>3) + 40960.
    - else: yp = (a>>2) + 32768.
  - FIX: y = sign ? 65536 - yp : yp. out_data = (y + 128) >> 8 (round half up), saturated to 256.
  - SEND: out_start = 1 for exactly this cycle; out_data is held stable from SEND until the next FIX. sample_cnt increments. The watchdog is cleared.
  - WAIT_ACK: out_ack is sampled each cycle. On ack -> IDLE. If the watchdog reaches ACK_TIMEOUT -> ack_err = 1, go to IDLE. out_ack in any other state is ignored.
- Latency: in_valid sampled at edge k with the block idle and pending empty gives out_start high in the cycle following edge k+4. Minimum throughput is one sample per 6 cycles.
- Input while busy: if the pending buffer is empty, store in_data in it. If it is full, drop the new sample and set overrun. The stored sample is not overwritten.
- out_start is never asserted for two consecutive cycles. The next neuron shifts its FIFO on every cycle its start input is high.
- All arithmetic is unsigned after ABS. Intermediates are at least 24 bits, so no wrap is possible.

Test Plan:
- Reset, then idle 10 cycles -> out_start never asserted; all outputs 0.
- Single in_valid each with in_data = 0x000000, 0x008000 (0.5), 0x010000 (1.0), 0x030000 (3.0), 0x050000 (5.0) -> out_data = 128, 160, 192, 240, 256. Each out_start occurs 5 cycles after in_valid, with out_ack returned the next cycle.
- Negative and extreme inputs 0xFF0000 (-1.0), 0x7FFFFF, 0x800000 -> 64, 256, 0. Rounding: 0x000200 -> 129 and 0xFFFE00 -> 128.
- Three in_valid pulses on consecutive cycles -> first two samples emitted in order, third dropped, overrun = 1, sample_cnt = 2.
- out_ack held low, ACK_TIMEOUT = 8 -> ack_err = 1 after 8 WAIT_ACK cycles. The FSM returns to IDLE and accepts the next input normally.
- Assert reset during the SEG state, then send 0x010000 -> no out_start for the aborted sample; next out_data = 192, sample_cnt = 1.
